// File: rtl/mib_slave.sv
// MIB bus slave: decodes a master transaction on the multiplexed AD bus, issues one
// local command, then returns a write ack or two read-data beats.
module mib_slave #(
  parameter logic [7:0] P_MIB_SLAVE_ADDR       = 8'h00,
  parameter int         P_CMD_ACK_TIMEOUT_CLKS = 16
) (
  input  logic        i_sysclk,
  input  logic        i_arst_n,
  input  logic        i_mib_start,
  input  logic        i_mib_rd_wr_n,
  input  logic [15:0] i_mib_ad,
  output logic [15:0] o_mib_ad,
  output logic        o_mib_ad_high_z,
  output logic        o_mib_slave_ack,
  output logic        o_cmd_sel,
  output logic        o_cmd_rd_wr_n,
  output logic [15:0] o_cmd_byte_addr,
  output logic [31:0] o_cmd_wdata,
  input  logic [31:0] i_cmd_rdata,
  input  logic        i_cmd_ack,
  output logic        o_cmd_timeout,
  output logic [2:0]  o_dbg_state
);

  localparam int LP_CNT_W = (P_CMD_ACK_TIMEOUT_CLKS > 1) ? $clog2(P_CMD_ACK_TIMEOUT_CLKS) : 1;
  localparam logic [LP_CNT_W-1:0] LP_CNT_LAST = LP_CNT_W'(P_CMD_ACK_TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR_LO, S_WDATA_HI, S_WDATA_LO, S_CMD_WAIT, S_RDATA_HI, S_RDATA_LO
  } state_t;

  state_t               r_state, w_state;
  logic                 r_rd_wr_n, w_rd_wr_n;
  logic [15:0]          r_rdata_lo, w_rdata_lo;
  logic [LP_CNT_W-1:0]  r_cnt, w_cnt;
  logic [15:0]          r_mib_ad, w_mib_ad;
  logic                 r_high_z, w_high_z;
  logic                 r_slave_ack, w_slave_ack;
  logic                 r_cmd_sel, w_cmd_sel;
  logic                 r_cmd_rd_wr_n, w_cmd_rd_wr_n;
  logic [15:0]          r_cmd_byte_addr, w_cmd_byte_addr;
  logic [31:0]          r_cmd_wdata, w_cmd_wdata;
  logic                 r_cmd_timeout, w_cmd_timeout;

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Command handshake: o_cmd_sel is a one-cycle request whose address/data/type stay
  // stable until completion; i_cmd_ack is a one-cycle completion pulse honoured only
  // in CMD_WAIT (including the sel cycle itself), and it beats a coincident timeout.
  always_comb begin
    w_state         = r_state;
    w_rd_wr_n       = r_rd_wr_n;
    w_rdata_lo      = r_rdata_lo;
    w_cnt           = '0;
    w_mib_ad        = r_mib_ad;
    w_high_z        = 1'b1;
    w_slave_ack     = 1'b0;
    w_cmd_sel       = 1'b0;
    w_cmd_rd_wr_n   = r_cmd_rd_wr_n;
    w_cmd_byte_addr = r_cmd_byte_addr;
    w_cmd_wdata     = r_cmd_wdata;
    w_cmd_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_mib_start && (i_mib_ad[7:0] == P_MIB_SLAVE_ADDR)) begin
          w_rd_wr_n = i_mib_rd_wr_n;
          w_state   = S_ADDR_LO;
        end
      end
      S_ADDR_LO: begin
        w_cmd_byte_addr = i_mib_ad;
        if (r_rd_wr_n) begin
          w_cmd_sel     = 1'b1;
          w_cmd_rd_wr_n = 1'b1;
          w_state       = S_CMD_WAIT;
        end else begin
          w_state = S_WDATA_HI;
        end
      end
      S_WDATA_HI: begin
        w_cmd_wdata[31:16] = i_mib_ad;
        w_state            = S_WDATA_LO;
      end
      S_WDATA_LO: begin
        w_cmd_wdata[15:0] = i_mib_ad;
        w_cmd_sel         = 1'b1;
        w_cmd_rd_wr_n     = 1'b0;
        w_state           = S_CMD_WAIT;
      end
      S_CMD_WAIT: begin
        if (i_cmd_ack) begin
          w_slave_ack = 1'b1;
          if (r_rd_wr_n) begin
            w_rdata_lo = i_cmd_rdata[15:0];
            w_mib_ad   = i_cmd_rdata[31:16];
            w_high_z   = 1'b0;
            w_state    = S_RDATA_HI;
          end else begin
            w_state = S_IDLE;
          end
        end else if (r_cnt == LP_CNT_LAST) begin
          w_cmd_timeout = 1'b1;
          w_state       = S_IDLE;
        end else begin
          w_cnt = r_cnt + LP_CNT_W'(1);
        end
      end
      S_RDATA_HI: begin
        w_mib_ad = r_rdata_lo;
        w_high_z = 1'b0;
        w_state  = S_RDATA_LO;
      end
      S_RDATA_LO: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_sysclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_rd_wr_n       <= 1'b0;
      r_rdata_lo      <= '0;
      r_cnt           <= '0;
      r_mib_ad        <= '0;
      r_high_z        <= 1'b1;
      r_slave_ack     <= 1'b0;
      r_cmd_sel       <= 1'b0;
      r_cmd_rd_wr_n   <= 1'b0;
      r_cmd_byte_addr <= '0;
      r_cmd_wdata     <= '0;
      r_cmd_timeout   <= 1'b0;
    end else begin
      r_rd_wr_n       <= w_rd_wr_n;
      r_rdata_lo      <= w_rdata_lo;
      r_cnt           <= w_cnt;
      r_mib_ad        <= w_mib_ad;
      r_high_z        <= w_high_z;
      r_slave_ack     <= w_slave_ack;
      r_cmd_sel       <= w_cmd_sel;
      r_cmd_rd_wr_n   <= w_cmd_rd_wr_n;
      r_cmd_byte_addr <= w_cmd_byte_addr;
      r_cmd_wdata     <= w_cmd_wdata;
      r_cmd_timeout   <= w_cmd_timeout;
    end
  end

  assign o_mib_ad        = r_mib_ad;
  assign o_mib_ad_high_z = r_high_z;
  assign o_mib_slave_ack = r_slave_ack;
  assign o_cmd_sel       = r_cmd_sel;
  assign o_cmd_rd_wr_n   = r_cmd_rd_wr_n;
  assign o_cmd_byte_addr = r_cmd_byte_addr;
  assign o_cmd_wdata     = r_cmd_wdata;
  assign o_cmd_timeout   = r_cmd_timeout;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mib_slave.sv
// Bench for mib_slave: directed and random MIB transactions, a command responder,
// and a monitor that checks every DUT output event against expected queues.
module tb_mib_slave;

  localparam logic [7:0] SLV = 8'h12;
  localparam int         TO  = 16;
  localparam int         NEVER = 1000;

  logic        clk, rst_n;
  logic        i_mib_start, i_mib_rd_wr_n;
  logic [15:0] i_mib_ad;
  logic [15:0] o_mib_ad;
  logic        o_mib_ad_high_z, o_mib_slave_ack;
  logic        o_cmd_sel, o_cmd_rd_wr_n;
  logic [15:0] o_cmd_byte_addr;
  logic [31:0] o_cmd_wdata;
  logic [31:0] i_cmd_rdata;
  logic        i_cmd_ack;
  logic        o_cmd_timeout;
  logic [2:0]  o_dbg_state;

  mib_slave #(.P_MIB_SLAVE_ADDR(SLV), .P_CMD_ACK_TIMEOUT_CLKS(TO)) dut (
    .i_sysclk(clk), .i_arst_n(rst_n),
    .i_mib_start(i_mib_start), .i_mib_rd_wr_n(i_mib_rd_wr_n), .i_mib_ad(i_mib_ad),
    .o_mib_ad(o_mib_ad), .o_mib_ad_high_z(o_mib_ad_high_z), .o_mib_slave_ack(o_mib_slave_ack),
    .o_cmd_sel(o_cmd_sel), .o_cmd_rd_wr_n(o_cmd_rd_wr_n), .o_cmd_byte_addr(o_cmd_byte_addr),
    .o_cmd_wdata(o_cmd_wdata), .i_cmd_rdata(i_cmd_rdata), .i_cmd_ack(i_cmd_ack),
    .o_cmd_timeout(o_cmd_timeout), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  logic [48:0] exp_cmd_q[$];   // {rd, addr, wdata}
  logic [17:0] exp_mib_q[$];   // {ack, high_z, ad}
  logic [31:0] exp_to_q[$];    // cycles from sel to timeout
  int          resp_dly_q[$];
  logic [31:0] resp_dat_q[$];
  bit          resp_busy;
  int          n_vec, n_err;
  int          cyc, sel_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    cyc = 0;
    sel_cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (o_cmd_sel) begin
        sel_cyc = cyc;
        if (exp_cmd_q.size() == 0) begin
          check("unexpected_cmd_sel", 1, 0);
        end else begin
          logic [48:0] e;
          e = exp_cmd_q.pop_front();
          check("cmd_rd_wr_n", o_cmd_rd_wr_n, e[48]);
          check("cmd_byte_addr", o_cmd_byte_addr, e[47:32]);
          if (!e[48]) check("cmd_wdata", o_cmd_wdata, e[31:0]);
        end
      end
      if (o_mib_slave_ack || !o_mib_ad_high_z) begin
        if (exp_mib_q.size() == 0) begin
          check("unexpected_mib_beat", {o_mib_slave_ack, o_mib_ad_high_z}, 2'b01);
        end else begin
          logic [17:0] m;
          m = exp_mib_q.pop_front();
          check("mib_ack_hz", {o_mib_slave_ack, o_mib_ad_high_z}, m[17:16]);
          if (!m[16]) check("mib_ad", o_mib_ad, m[15:0]);
        end
      end
      if (o_cmd_timeout) begin
        if (exp_to_q.size() == 0) begin
          check("unexpected_timeout", 1, 0);
        end else begin
          logic [31:0] t;
          t = exp_to_q.pop_front();
          check("timeout_latency", cyc - sel_cyc, t);
        end
      end
    end
  end

  // ---------------- command responder ----------------
  initial begin
    i_cmd_ack   = 1'b0;
    i_cmd_rdata = '0;
    resp_busy   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (o_cmd_sel && resp_dly_q.size() > 0) begin
        int d;
        logic [31:0] rd;
        d  = resp_dly_q.pop_front();
        rd = resp_dat_q.pop_front();
        if (d < NEVER) begin
          resp_busy = 1'b1;
          repeat (d) begin
            @(posedge clk);
            #1;
          end
          i_cmd_ack   = 1'b1;
          i_cmd_rdata = rd;
          @(posedge clk);
          #1;
          i_cmd_ack   = 1'b0;
          i_cmd_rdata = $urandom;
          resp_busy   = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic flush_all();
    exp_cmd_q.delete();
    exp_mib_q.delete();
    exp_to_q.delete();
    resp_dly_q.delete();
    resp_dat_q.delete();
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(posedge clk);
      #3;
      done = (exp_cmd_q.size() == 0) && (exp_mib_q.size() == 0) && (exp_to_q.size() == 0) &&
             (resp_dly_q.size() == 0) && !resp_busy;
    end
    if (!done) begin
      check("drain_timeout", 0, 1);
      flush_all();
    end
    repeat (2) @(posedge clk);
  endtask

  // Reference model: a matching start yields one command; an ack within the
  // timeout window yields a write ack or two read beats, otherwise one timeout.
  task automatic model_push(input bit rd, input logic [15:0] addr, input logic [31:0] wd,
                            input logic [31:0] rdat, input int dly, input bit ack_only_hi);
    exp_cmd_q.push_back({rd, addr, wd});
    resp_dly_q.push_back(dly);
    resp_dat_q.push_back(rdat);
    if (dly <= TO - 1) begin
      if (rd) begin
        exp_mib_q.push_back({2'b10, rdat[31:16]});
        if (!ack_only_hi) exp_mib_q.push_back({2'b00, rdat[15:0]});
      end else begin
        exp_mib_q.push_back({2'b11, 16'h0000});
      end
    end else begin
      exp_to_q.push_back(TO);
    end
  endtask

  task automatic drive_phases(input bit rd, input logic [7:0] sa, input logic [15:0] addr,
                              input logic [31:0] wd, input bit noise);
    @(posedge clk); #1;
    i_mib_start = 1'b1; i_mib_rd_wr_n = rd; i_mib_ad = {8'($urandom), sa};
    @(posedge clk); #1;
    i_mib_start = noise ? 1'($urandom) : 1'b0; i_mib_rd_wr_n = 1'($urandom); i_mib_ad = addr;
    if (!rd) begin
      @(posedge clk); #1;
      i_mib_start = noise ? 1'($urandom) : 1'b0; i_mib_ad = wd[31:16];
      @(posedge clk); #1;
      i_mib_start = noise ? 1'($urandom) : 1'b0; i_mib_ad = wd[15:0];
    end
    @(posedge clk); #1;
    i_mib_start = 1'b0; i_mib_ad = 16'($urandom);
  endtask

  task automatic mib_txn(input bit rd, input logic [7:0] sa, input logic [15:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat, input int dly,
                         input bit noise);
    bit hit;
    hit = (sa == SLV);
    if (hit) model_push(rd, addr, wd, rdat, dly, 1'b0);
    drive_phases(rd, sa, addr, wd, noise && hit);
    wait_drain();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    i_mib_start = 1'b0; i_mib_rd_wr_n = 1'b0; i_mib_ad = '0;
    #2 rst_n = 1'b0;
    #2;
    check("rst_high_z", o_mib_ad_high_z, 1);
    check("rst_slave_ack", o_mib_slave_ack, 0);
    check("rst_cmd_sel", o_cmd_sel, 0);
    check("rst_cmd_timeout", o_cmd_timeout, 0);
    check("rst_cmd_rd_wr_n", o_cmd_rd_wr_n, 0);
    check("rst_mib_ad", o_mib_ad, 0);
    check("rst_byte_addr", o_cmd_byte_addr, 0);
    check("rst_wdata", o_cmd_wdata, 0);
    #18 rst_n = 1'b1;

    mib_txn(1'b0, SLV, 16'hABCD, 32'hDEADBEEF, 32'h0, 2, 1'b0);
    mib_txn(1'b1, SLV, 16'h0040, 32'h0, 32'h12345678, 1, 1'b0);
    mib_txn(1'b1, 8'h13, 16'h0040, 32'h0, 32'h0, 0, 1'b0);
    mib_txn(1'b0, SLV, 16'h1000, 32'hCAFEF00D, 32'h0, NEVER, 1'b0);
    mib_txn(1'b1, SLV, 16'h2002, 32'h0, 32'h89ABCDEF, 3, 1'b0);
    mib_txn(1'b0, SLV, 16'h3012, 32'h01234567, 32'h0, 0, 1'b0);
    mib_txn(1'b1, SLV, 16'h4004, 32'h0, 32'hA5A55A5A, TO - 1, 1'b0);
    mib_txn(1'b0, SLV, 16'h5006, 32'h76543210, 32'h0, TO, 1'b0);

    // asynchronous reset while the high read beat is on the bus
    model_push(1'b1, 16'h0080, 32'h0, 32'hFEEDFACE, 2, 1'b1);
    drive_phases(1'b1, SLV, 16'h0080, 32'h0, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge clk);
        #1;
        seen = o_mib_slave_ack;
      end
      check("rdata_hi_reached", seen, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_high_z", o_mib_ad_high_z, 1);
    check("midrst_slave_ack", o_mib_slave_ack, 0);
    check("midrst_mib_ad", o_mib_ad, 0);
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    flush_all();
    repeat (2) @(posedge clk);
    mib_txn(1'b1, SLV, 16'h00C0, 32'h0, 32'h0BADBEEF, 2, 1'b0);

    for (int n = 0; n < 40; n++) begin
      bit          rd;
      logic [7:0]  sa;
      logic [15:0] addr;
      int          dly;
      rd   = 1'($urandom_range(0, 1));
      sa   = ($urandom_range(0, 4) == 0) ? 8'($urandom) : SLV;
      addr = 16'($urandom);
      if ($urandom_range(0, 1) == 1) addr[7:0] = SLV;
      dly  = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 20));
      mib_txn(rd, sa, addr, $urandom, $urandom, dly, 1'b1);
    end

    check("end_cmd_q_empty", exp_cmd_q.size(), 0);
    check("end_mib_q_empty", exp_mib_q.size(), 0);
    check("end_to_q_empty", exp_to_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mib_slave.md
MIB_SLAVE -- requirements
Module: mib_slave

Interface
REQ-001 SHALL have parameter P_MIB_SLAVE_ADDR, default 8'h00, MIB slave select matched against address-phase-1 AD[7:0].
REQ-002 SHALL have parameter P_CMD_ACK_TIMEOUT_CLKS, default 16, cycles to wait for i_cmd_ack; must be less than the master MIB ACK timeout of 32.
REQ-003 SHALL have one clock and an asynchronous active-low reset, listed first:
- i_sysclk  in  1  sole clock.
- i_arst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have these MIB bus ports:
- i_mib_start  in  1  one-clock start pulse from master.
- i_mib_rd_wr_n  in  1  1 = read, 0 = write; valid with i_mib_start.
- i_mib_ad  in  16  master-driven address/write data.
- o_mib_ad  out  16  slave-driven read data.
- o_mib_ad_high_z  out  1  1 = tri-state AD at top level, 0 = drive.
- o_mib_slave_ack  out  1  write ack or read-data-valid pulse.
REQ-005 SHALL have these command-master ports:
- o_cmd_sel  out  1  one-clock request pulse.
- o_cmd_rd_wr_n  out  1  request type.
- o_cmd_byte_addr  out  16  local byte address.
- o_cmd_wdata  out  32  write data.
- i_cmd_rdata  in  32  read data, valid with i_cmd_ack.
- i_cmd_ack  in  1  one-clock completion pulse.
- o_cmd_timeout  out  1  one-clock pulse on command timeout.

Function
REQ-006 SHALL sample all MIB and cmd inputs directly on the i_sysclk rising edge; all outputs SHALL be registered.
REQ-007 SHALL implement FSM states IDLE, ADDR_LO, WDATA_HI, WDATA_LO, CMD_WAIT, RDATA_HI, RDATA_LO.
REQ-008 SHALL, in IDLE, on i_mib_start=1 and i_mib_ad[7:0]==P_MIB_SLAVE_ADDR, latch i_mib_rd_wr_n and go to ADDR_LO.
REQ-009 SHALL, in IDLE, ignore non-matching starts entirely: no drive, no ack.
REQ-010 SHALL ignore i_mib_start in every state other than IDLE.
REQ-011 SHALL, in ADDR_LO, latch i_mib_ad into o_cmd_byte_addr.
- Read: assert o_cmd_sel with o_cmd_rd_wr_n=1 and go to CMD_WAIT.
- Write: go to WDATA_HI.
REQ-012 SHALL, in WDATA_HI, latch i_mib_ad into o_cmd_wdata[31:16] and go to WDATA_LO.
REQ-013 SHALL, in WDATA_LO, latch i_mib_ad into o_cmd_wdata[15:0], assert o_cmd_sel with o_cmd_rd_wr_n=0, and go to CMD_WAIT.
REQ-014 SHALL hold o_cmd_sel high for exactly one cycle per transaction.
REQ-015 SHALL hold o_cmd_byte_addr, o_cmd_wdata and o_cmd_rd_wr_n stable from o_cmd_sel until the FSM leaves CMD_WAIT.
REQ-016 SHALL accept i_cmd_ack in any CMD_WAIT cycle, including the cycle o_cmd_sel is high.
REQ-017 SHALL, on i_cmd_ack in CMD_WAIT:
- Write: pulse o_mib_slave_ack for one cycle with o_mib_ad_high_z=1, then return to IDLE.
- Read: latch i_cmd_rdata and go to RDATA_HI.
REQ-018 SHALL, in RDATA_HI, output o_mib_ad=rdata[31:16], o_mib_slave_ack=1, o_mib_ad_high_z=0.
REQ-019 SHALL, in RDATA_LO, output o_mib_ad=rdata[15:0], o_mib_slave_ack=0, o_mib_ad_high_z=0, then return to IDLE with o_mib_ad_high_z=1.
REQ-020 SHALL drive o_mib_ad_high_z=0 only during the RDATA_HI and RDATA_LO output cycles.
REQ-021 SHALL run a timeout counter of width $clog2(P_CMD_ACK_TIMEOUT_CLKS), cleared outside CMD_WAIT and incremented each CMD_WAIT cycle without ack.
REQ-022 SHALL, when the counter equals P_CMD_ACK_TIMEOUT_CLKS-1 with no ack, pulse o_cmd_timeout for one cycle, issue no MIB ack, and return to IDLE.
REQ-023 SHALL let i_cmd_ack win over timeout when both occur in the same cycle.
REQ-024 SHALL ignore i_cmd_ack outside CMD_WAIT.
REQ-025 SHALL keep o_mib_slave_ack, o_cmd_sel and o_cmd_timeout single-cycle pulses, low by default.

Reset
REQ-026 SHALL, on i_arst_n=0 (asynchronous, including mid-transaction), immediately apply:
- FSM to IDLE.
- o_mib_ad_high_z=1.
- o_mib_slave_ack, o_cmd_sel, o_cmd_timeout, o_cmd_rd_wr_n = 0.
- o_mib_ad, o_cmd_byte_addr, o_cmd_wdata, timeout counter = 0.
REQ-027 SHALL, after reset release, respond only to an i_mib_start received in IDLE.

Verification
REQ-028 Write: start with AD=0x0012 (P_MIB_SLAVE_ADDR=8'h12), then 0xABCD, 0xDEAD, 0xBEEF; ack two cycles after sel -> o_cmd_sel pulses once with addr 0xABCD, wdata 0xDEADBEEF, wr; one o_mib_slave_ack pulse with high_z=1 throughout.
REQ-029 Read: addr 0x0040; cmd returns rdata 0x12345678 -> consecutive cycles (0x1234, ack=1, high_z=0), then (0x5678, ack=0, high_z=0), then high_z=1.
REQ-030 Address mismatch: start with AD=0x0013 -> no o_cmd_sel, no ack, high_z stays 1.
REQ-031 Timeout: no i_cmd_ack -> o_cmd_timeout pulses exactly P_CMD_ACK_TIMEOUT_CLKS cycles after entering CMD_WAIT, no MIB ack; a following read then completes normally.
REQ-032 Reset asserted during RDATA_HI -> high_z=1 and ack=0 immediately, without waiting for a clock edge; FSM in IDLE; next transaction is correct.
REQ-033 Same-cycle ack: i_cmd_ack in the o_cmd_sel cycle -> accepted; ack on the final timeout cycle -> ack wins, no o_cmd_timeout.
